fft4_serial_packer: RTL and testbench
=====================================

Name: fft4_serial_packer

Overview:
Front-end feeder for parallel_mul_twiddle_FFT4: the transmit side of its 4-lane valid/lable input interface. Accepts one complex sample per cycle from a serial source, saturates it from IN_WIDTH to DATA_WIDTH, and groups four consecutive samples into one parallel beat on x0..x3. Each beat carries a group label, 0..GROUPS-1. One frame is N_POINTS samples (GROUPS = N_POINTS/4 beats).

Parameters:
IN_WIDTH, 32, signed width of each serial real/imag input component
DATA_WIDTH, 21, signed width of each packed output component (must be <= IN_WIDTH)
N_POINTS, 8192, samples per frame (multiple of 4)
LABLE_WIDTH, 11, width of lable; must satisfy 2^LABLE_WIDTH >= N_POINTS/4

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_valid  in  1  serial sample valid; sampled on rising clk
s_sop  in  1  start of frame; qualified by s_valid
s_data_r  in  IN_WIDTH  signed real part
s_data_i  in  IN_WIDTH  signed imag part
x0_r,x0_i,x1_r,x1_i,x2_r,x2_i,x3_r,x3_i  out  DATA_WIDTH each  packed lanes; lane k = k-th sample of the group
valid  out  1  packed beat valid, one cycle per group
lable  out  LABLE_WIDTH  group index within frame
frame_done  out  1  pulse with the beat whose lable = GROUPS-1
sat_flag  out  1  sticky: some sample in the current frame saturated
sop_err  out  1  one-cycle pulse: s_sop arrived mid-frame

Behaviour:
- Reset (async assert, sync release): all outputs are 0. lane_cnt=0, grp_cnt=0. State = IDLE.
- States:
  - IDLE: samples are ignored until s_valid && s_sop. That sample becomes lane 0. Go to RUN.
  - RUN: each s_valid sample is written to lane lane_cnt, and lane_cnt increments mod 4.
- Saturation: each component is clamped independently to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. In-range values pass through unchanged (sign-preserving truncation of the upper bits).
  - Any clamp sets sat_flag.
  - sat_flag is cleared on each accepted s_sop. If a clamp occurs on that same sample, the flag ends up set.
- Emit: when the lane-3 sample is accepted at edge t, the registered outputs show the full group from edge t+1. Latency is 1 cycle from the 4th sample.
  - valid=1 for exactly one cycle, with lable=grp_cnt.
  - grp_cnt then increments.
  - In cycles where valid=0, all x* and lable outputs are 0. The consumer bench requires zeroed data when invalid.
- Gaps: s_valid may drop at any point. The partial group is held and no beat is emitted. Throughput is at most one beat per 4 accepted samples.
- Frame end: the beat with lable=GROUPS-1 also asserts frame_done. grp_cnt wraps to 0 and the state returns to IDLE. The next frame requires s_sop.
- s_sop while in RUN with lane_cnt!=0 or grp_cnt!=0:
  - The partial group is discarded and sop_err pulses the next cycle.
  - That sample becomes lane 0 of a new frame and grp_cnt resets to 0.
  - No beat is emitted for the discarded samples.
- s_sop on the sample right after frame end (state IDLE) is the normal case and raises no error.
- s_sop with s_valid=0 is ignored.
- Reset mid-frame discards everything, and outputs go to 0 asynchronously.

Test Plan:
- Nominal frame:
  - Stimulus: reset, then 8192 back-to-back samples with s_data_r=i, s_data_i=-i, s_sop on i=0.
  - Required: 2048 valid beats, each one cycle after every 4th sample. Beat g has lable=g, x0_r=4g … x3_r=4g+3, x*_i negated.
  - Required: frame_done only at g=2047, sat_flag=0.
- Saturation:
  - Stimulus: sample 1 = (0x00100000, 0xFFF00000), sample 2 = (0x7FFFFFFF, 0x80000000).
  - Required: x1 = (0x0FFFFF, 0x100000), x2 = (0x0FFFFF, 0x100000) in 21-bit.
  - Required: sat_flag=1 until the next s_sop.
- Gaps:
  - Stimulus: s_valid toggled 1,0,0,1,1,0,1.
  - Required: exactly one beat, one cycle after the 4th accepted sample, with lable=0 and the correct lane order.
  - Required: valid=0 and x*=0 at all other cycles.
- Mid-frame sop:
  - Stimulus: 6 samples (beat lable=0 emitted, lane_cnt=2), then s_sop.
  - Required: sop_err pulse, 2 samples dropped, next beat has lable=0 with data from the new frame.
- Back-to-back frames and no-sop:
  - Stimulus: frame A, then immediately frame B.
  - Required: lable wraps 2047→0, no sop_err.
  - Stimulus: samples without s_sop after frame end.
  - Required: ignored, no beats.
- Async reset:
  - Stimulus: assert rst mid-group (lane_cnt=3, valid pending).
  - Required: outputs 0 immediately, no beat after release, next s_sop starts at lable=0.

Source files
------------

// File: rtl/fft4_serial_packer_if.sv
// Serial sample input and 4-lane packed output bundle of the FFT4 front-end packer.
// master = the packer itself, slave = the sample source / beat consumer side.
interface fft4_serial_packer_if #(
    parameter int IN_WIDTH    = 32,
    parameter int DATA_WIDTH  = 21,
    parameter int LABLE_WIDTH = 11
);
    logic                          s_valid;
    logic                          s_sop;
    logic signed [IN_WIDTH-1:0]    s_data_r;
    logic signed [IN_WIDTH-1:0]    s_data_i;

    logic signed [DATA_WIDTH-1:0]  x0_r, x0_i;
    logic signed [DATA_WIDTH-1:0]  x1_r, x1_i;
    logic signed [DATA_WIDTH-1:0]  x2_r, x2_i;
    logic signed [DATA_WIDTH-1:0]  x3_r, x3_i;
    logic                          valid;
    logic [LABLE_WIDTH-1:0]        lable;
    logic                          frame_done;
    logic                          sat_flag;
    logic                          sop_err;

    modport master (
        input  s_valid, s_sop, s_data_r, s_data_i,
        output x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i,
        output valid, lable, frame_done, sat_flag, sop_err
    );

    modport slave (
        output s_valid, s_sop, s_data_r, s_data_i,
        input  x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i,
        input  valid, lable, frame_done, sat_flag, sop_err
    );
endinterface

// File: rtl/fft4_serial_packer.sv
// Serial-to-4-lane packer: saturates each complex sample and emits one labelled
// beat per four accepted samples, framed by s_sop.

// Signed clamp of one component; in-range values keep their low bits unchanged.
module fft4_sat #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 21
) (
    input  logic [IN_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  clamped
);
    logic [IN_WIDTH-DATA_WIDTH:0] hi;

    // Representable iff all bits above the target sign bit copy the sign.
    assign hi      = din[IN_WIDTH-1:DATA_WIDTH-1];
    assign clamped = !((hi == '0) || (hi == '1));
    assign dout    = clamped ? {din[IN_WIDTH-1], {(DATA_WIDTH-1){~din[IN_WIDTH-1]}}}
                             : din[DATA_WIDTH-1:0];
endmodule

// One output lane: holds its sample until the group completes, then drives it
// for a single cycle and zero otherwise.
module fft4_lane #(
    parameter int DATA_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  emit,
    input  logic [DATA_WIDTH-1:0] din_r,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_r,
    output logic [DATA_WIDTH-1:0] dout_i
);
    logic [DATA_WIDTH-1:0] hold_r, hold_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= '0;
            hold_i <= '0;
        end else if (wr_en) begin
            hold_r <= din_r;
            hold_i <= din_i;
        end
    end

    // The lane written in the emit cycle (the last one) forwards its live sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= '0;
            dout_i <= '0;
        end else if (emit) begin
            dout_r <= wr_en ? din_r : hold_r;
            dout_i <= wr_en ? din_i : hold_i;
        end else begin
            dout_r <= '0;
            dout_i <= '0;
        end
    end
endmodule

module fft4_serial_packer #(
    parameter int IN_WIDTH    = 32,
    parameter int DATA_WIDTH  = 21,
    parameter int N_POINTS    = 8192,
    parameter int LABLE_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    fft4_serial_packer_if.master bus
);
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;
    localparam int GROUPS    = N_POINTS / NUM_LANES;
    localparam logic [LABLE_WIDTH-1:0] LAST_GRP  = LABLE_WIDTH'(GROUPS - 1);
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0] i;
    } sample_t;

    state_t                  state_q, state_d;
    logic [LANE_W-1:0]       lane_cnt, lane_sel;
    logic [LABLE_WIDTH-1:0]  grp_cnt, grp_sel;
    logic                    accept, restart, emit, last_grp, err_d;
    logic                    clamp_r, clamp_i;
    sample_t                 smp;
    logic [NUM_LANES-1:0]    wr_lane;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_r, lane_i;

    logic                    valid_q, done_q, err_q, sat_q;
    logic [LABLE_WIDTH-1:0]  lable_q;

    fft4_sat #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sat_r (
        .din(bus.s_data_r), .dout(smp.r), .clamped(clamp_r)
    );
    fft4_sat #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sat_i (
        .din(bus.s_data_i), .dout(smp.i), .clamped(clamp_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        restart = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.s_valid && bus.s_sop) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.s_valid) begin
                    accept = 1'b1;
                    // A mid-frame sop drops the partial group and opens a new frame.
                    if (bus.s_sop) begin
                        restart = 1'b1;
                        err_d   = (lane_cnt != '0) || (grp_cnt != '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        lane_sel = restart ? '0 : lane_cnt;
        grp_sel  = restart ? '0 : grp_cnt;
        emit     = accept && (lane_sel == LAST_LANE);
        last_grp = emit && (grp_sel == LAST_GRP);
        if (last_grp) state_d = IDLE;
    end

    always_comb begin
        wr_lane = '0;
        if (accept) wr_lane[lane_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            grp_cnt  <= '0;
        end else if (accept) begin
            lane_cnt <= lane_sel + 1'b1;
            if (!emit)         grp_cnt <= grp_sel;
            else if (last_grp) grp_cnt <= '0;
            else               grp_cnt <= grp_sel + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            lable_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= emit;
            lable_q <= emit ? grp_sel : '0;
            done_q  <= last_grp;
            err_q   <= err_d;
            // Sticky per frame: a new sop clears, but its own clamp still counts.
            if (accept) sat_q <= (sat_q && !restart) || clamp_r || clamp_i;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fft4_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_lane[k]),
            .emit   (emit),
            .din_r  (smp.r),
            .din_i  (smp.i),
            .dout_r (lane_r[k]),
            .dout_i (lane_i[k])
        );
    end

    assign bus.x0_r       = lane_r[0];
    assign bus.x0_i       = lane_i[0];
    assign bus.x1_r       = lane_r[1];
    assign bus.x1_i       = lane_i[1];
    assign bus.x2_r       = lane_r[2];
    assign bus.x2_i       = lane_i[2];
    assign bus.x3_r       = lane_r[3];
    assign bus.x3_i       = lane_i[3];
    assign bus.valid      = valid_q;
    assign bus.lable      = lable_q;
    assign bus.frame_done = done_q;
    assign bus.sop_err    = err_q;
    assign bus.sat_flag   = sat_q;

    a_done_has_valid: assert property (@(posedge clk) disable iff (rst)
        bus.frame_done |-> bus.valid);
    a_idle_lable_zero: assert property (@(posedge clk) disable iff (rst)
        !bus.valid |-> (bus.lable == '0));
endmodule

// File: tb/tb_fft4_serial_packer.sv
// Bench for fft4_serial_packer: queue-based frame model checked every cycle,
// plus literal expectations for each scenario.
module tb_fft4_serial_packer;
    localparam int IW = 32;
    localparam int DW = 21;
    localparam int NP = 8192;
    localparam int LW = 11;
    localparam int GROUPS = NP / 4;

    typedef struct packed {
        logic [LW-1:0]         lable;
        logic                  done;
        logic [3:0][DW-1:0]    r;
        logic [3:0][DW-1:0]    i;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int n_err = 0;
    int err0 = 0;
    beat_t beats[$];
    logic [6:0] gap_pat = 7'b1011001;

    // model state
    bit               m_in_frame = 0;
    int               m_g = 0;
    bit               m_sat = 0;
    logic [DW-1:0]    q_r[$];
    logic [DW-1:0]    q_i[$];
    logic             e_valid = 0, e_done = 0, e_err = 0, e_sat = 0;
    logic [LW-1:0]    e_lable = '0;
    logic [3:0][DW-1:0] e_r = '0, e_i = '0;

    fft4_serial_packer_if #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .LABLE_WIDTH(LW)) bus ();

    fft4_serial_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .N_POINTS(NP), .LABLE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] satf(input logic [IW-1:0] x, inout bit c);
        longint v  = longint'($signed(x));
        longint mx = (longint'(1) <<< (DW - 1)) - 1;
        longint mn = -mx - 1;
        if (v > mx) begin c = 1; v = mx; end
        else if (v < mn) begin c = 1; v = mn; end
        return v[DW-1:0];
    endfunction

    // Reference: frame buffer of accepted samples, popped four at a time.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_frame = 0; m_g = 0; m_sat = 0;
            q_r.delete(); q_i.delete();
            e_valid = 0; e_done = 0; e_err = 0; e_sat = 0; e_lable = '0; e_r = '0; e_i = '0;
        end else begin
            bit c;
            c = 0;
            e_valid = 0; e_done = 0; e_err = 0; e_lable = '0; e_r = '0; e_i = '0;
            if (bus.s_valid && (bus.s_sop || m_in_frame)) begin
                if (bus.s_sop) begin
                    e_err = m_in_frame && (q_r.size() != 0 || m_g != 0);
                    q_r.delete(); q_i.delete();
                    m_g = 0; m_in_frame = 1; m_sat = 0;
                end
                q_r.push_back(satf(bus.s_data_r, c));
                q_i.push_back(satf(bus.s_data_i, c));
                if (c) m_sat = 1;
                if (q_r.size() == 4) begin
                    e_valid = 1;
                    e_lable = LW'(m_g);
                    for (int k = 0; k < 4; k++) begin e_r[k] = q_r[k]; e_i[k] = q_i[k]; end
                    e_done = (m_g == GROUPS - 1);
                    q_r.delete(); q_i.delete();
                    if (e_done) begin m_in_frame = 0; m_g = 0; end
                    else m_g++;
                end
            end
            e_sat = m_sat;
        end
    end

    always @(negedge clk) begin
        logic [3:0][DW-1:0] gr, gi;
        gr = {bus.x3_r, bus.x2_r, bus.x1_r, bus.x0_r};
        gi = {bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
        if (bus.valid === 1'b1) beats.push_back('{lable: bus.lable, done: bus.frame_done, r: gr, i: gi});
        if (bus.sop_err === 1'b1) n_err++;
        checks++;
        if ({bus.valid, bus.lable, bus.frame_done, bus.sop_err, bus.sat_flag, gr, gi} !==
            {e_valid, e_lable, e_done, e_err, e_sat, e_r, e_i}) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got v=%b l=%0d d=%b e=%b s=%b r=%h i=%h exp v=%b l=%0d d=%b e=%b s=%b r=%h i=%h",
                     $time, bus.valid, bus.lable, bus.frame_done, bus.sop_err, bus.sat_flag, gr, gi,
                     e_valid, e_lable, e_done, e_err, e_sat, e_r, e_i);
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sop, input logic [IW-1:0] r, input logic [IW-1:0] i);
        @(negedge clk);
        bus.s_valid  = v;
        bus.s_sop    = sop;
        bus.s_data_r = r;
        bus.s_data_i = i;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    function automatic logic [IW-1:0] rnd_val();
        if ($urandom_range(15) == 0) return IW'($urandom());
        return IW'(int'($urandom_range(2097151)) - 1048576);
    endfunction

    task automatic send_frame();
        for (int s = 0; s < NP; s++) begin
            while ($urandom_range(3) == 0) drive(1'b0, 1'($urandom_range(1)), rnd_val(), rnd_val());
            drive(1'b1, s == 0, rnd_val(), rnd_val());
        end
    endtask

    function automatic int count_done();
        int n = 0;
        foreach (beats[k]) if (beats[k].done) n++;
        return n;
    endfunction

    initial begin
        bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_data_r = '0; bus.s_data_i = '0;
        rst = 1'b1;
        #1;
        chk("reset_valid", longint'(bus.valid), 0);
        chk("reset_sat", longint'(bus.sat_flag), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // nominal frame
        beats.delete();
        for (int i = 0; i < NP; i++) drive(1'b1, i == 0, IW'(i), IW'(-i));
        idle(2);
        chk("nom_beats", beats.size(), GROUPS);
        chk("nom_b0_lable", longint'(beats[0].lable), 0);
        chk("nom_b0_x3r", longint'($signed(beats[0].r[3])), 3);
        chk("nom_b0_x3i", longint'($signed(beats[0].i[3])), -3);
        chk("nom_last_lable", longint'(beats[GROUPS-1].lable), GROUPS - 1);
        chk("nom_last_x0r", longint'($signed(beats[GROUPS-1].r[0])), 4 * (GROUPS - 1));
        chk("nom_last_x3i", longint'($signed(beats[GROUPS-1].i[3])), -(4 * (GROUPS - 1) + 3));
        chk("nom_done_cnt", count_done(), 1);
        chk("nom_done_last", longint'(beats[GROUPS-1].done), 1);
        chk("nom_sat", longint'(bus.sat_flag), 0);
        chk("nom_err", n_err, 0);

        // saturation
        beats.delete();
        drive(1'b1, 1'b1, 5, 6);
        drive(1'b1, 1'b0, 32'h0010_0000, 32'hFFF0_0000);
        drive(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
        drive(1'b1, 1'b0, 7, 8);
        idle(2);
        chk("sat_beats", beats.size(), 1);
        chk("sat_x1r", longint'(beats[0].r[1]), 64'h0F_FFFF);
        chk("sat_x1i", longint'(beats[0].i[1]), 64'h10_0000);
        chk("sat_x2r", longint'(beats[0].r[2]), 64'h0F_FFFF);
        chk("sat_x2i", longint'(beats[0].i[2]), 64'h10_0000);
        chk("sat_flag_set", longint'(bus.sat_flag), 1);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1, 1);
        idle(2);
        chk("sat_flag_sticky", longint'(bus.sat_flag), 1);

        // gaps (sop arrives mid-frame here, the model expects the error pulse)
        beats.delete();
        begin
            int v = 100;
            for (int k = 0; k < 7; k++) begin
                if (gap_pat[k]) begin drive(1'b1, v == 100, IW'(v), IW'(-v)); v++; end
                else drive(1'b0, 1'b0, 999, 999);
            end
        end
        idle(3);
        chk("gap_beats", beats.size(), 1);
        chk("gap_lable", longint'(beats[0].lable), 0);
        chk("gap_x0r", longint'($signed(beats[0].r[0])), 100);
        chk("gap_x2r", longint'($signed(beats[0].r[2])), 102);
        chk("gap_x3i", longint'($signed(beats[0].i[3])), -103);
        chk("gap_sat_cleared", longint'(bus.sat_flag), 0);

        // mid-frame sop
        beats.delete();
        for (int k = 0; k < 6; k++) drive(1'b1, k == 0, IW'(200 + k), IW'(k));
        idle(2);
        err0 = n_err;
        for (int k = 0; k < 4; k++) drive(1'b1, k == 0, IW'(300 + k), IW'(-k));
        idle(2);
        chk("mid_err_pulse", n_err - err0, 1);
        chk("mid_beats", beats.size(), 2);
        chk("mid_b0_x0r", longint'($signed(beats[0].r[0])), 200);
        chk("mid_b1_lable", longint'(beats[1].lable), 0);
        chk("mid_b1_x0r", longint'($signed(beats[1].r[0])), 300);
        chk("mid_b1_x3r", longint'($signed(beats[1].r[3])), 303);

        // back-to-back random frames
        apply_reset();
        beats.delete();
        err0 = n_err;
        send_frame();
        send_frame();
        idle(2);
        chk("b2b_beats", beats.size(), 2 * GROUPS);
        chk("b2b_wrap_hi", longint'(beats[GROUPS-1].lable), GROUPS - 1);
        chk("b2b_wrap_lo", longint'(beats[GROUPS].lable), 0);
        chk("b2b_done_cnt", count_done(), 2);
        chk("b2b_no_err", n_err - err0, 0);

        // no sop after frame end, and sop without valid
        beats.delete();
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, rnd_val(), rnd_val());
        drive(1'b0, 1'b1, 1, 1);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 2, 2);
        idle(2);
        chk("nosop_beats", beats.size(), 0);

        // async reset with lane 3 pending
        beats.delete();
        drive(1'b1, 1'b1, 10, 10);
        drive(1'b1, 1'b0, 32'h7FFF_FFFF, 11);
        drive(1'b1, 1'b0, 12, 12);
        drive(1'b1, 1'b0, 13, 13);
        #1;
        chk("rst_sat_before", longint'(bus.sat_flag), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_sat", longint'(bus.sat_flag), 0);
        chk("rst_async_valid", longint'(bus.valid), 0);
        chk("rst_async_x0r", longint'(bus.x0_r), 0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 3, 3);
        idle(2);
        chk("rst_no_beat", beats.size(), 0);
        for (int k = 0; k < 4; k++) drive(1'b1, k == 0, IW'(40 + k), IW'(k));
        idle(2);
        chk("rst_new_beats", beats.size(), 1);
        chk("rst_new_lable", longint'(beats[0].lable), 0);
        chk("rst_new_x0r", longint'($signed(beats[0].r[0])), 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
